// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: widths, load/store size
// encodings, FSM states and the alignment/legality rule.
package mem_access_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int STRB_W     = DATA_W / 8;

    // funct3 encodings for loads and stores
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // A memory op may issue only with a legal size code and a naturally
    // aligned address for that size.
    function automatic logic access_ok(input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        case (funct3)
            LS_B, LS_BU: access_ok = 1'b1;
            LS_H, LS_HU: access_ok = ~addr_lo[0];
            LS_W:        access_ok = (addr_lo == 2'b00);
            default:     access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_lane.sv
// Combinational byte-lane steering: store data replication and write strobes,
// load byte/half extraction with sign or zero extension.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic              is_store_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] load_rdata_i,
    output logic [DATA_W-1:0] store_wdata_o,
    output logic [STRB_W-1:0] store_wstrb_o,
    output logic [DATA_W-1:0] load_result_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane_byte = load_rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_half = addr_lo_i[1] ? load_rdata_i[31:16] : load_rdata_i[15:0];

    // Store path: replicate the narrow value across the word, strobe the lanes it targets
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        store_wdata_o = '0;
        store_wstrb_o = '0;
        if (is_store_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    store_wdata_o = {4{store_data_i[7:0]}};
                    store_wstrb_o = 4'b0001 << addr_lo_i;
                end
                2'b01: begin
                    store_wdata_o = {2{store_data_i[15:0]}};
                    store_wstrb_o = 4'b0011 << addr_lo_i;
                end
                default: begin
                    store_wdata_o = store_data_i;
                    store_wstrb_o = 4'b1111;
                end
            endcase
        end
    end

    // Load path: pick the addressed byte/half and extend it to a full word
    always_comb begin
        load_result_o = load_rdata_i;
        case (funct3_i)
            LS_B:    load_result_o = {{24{lane_byte[7]}}, lane_byte};
            LS_BU:   load_result_o = {24'b0, lane_byte};
            LS_H:    load_result_o = {{16{lane_half[15]}}, lane_half};
            LS_HU:   load_result_o = {16'b0, lane_half};
            default: load_result_o = load_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results to write-back and runs
// loads/stores against data memory over a req/ack handshake, stalling the
// front of the pipeline while a transaction is outstanding.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_W,
    parameter int ADDR_WIDTH     = ADDR_W,
    parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ex_valid,
    input  logic [DATA_WIDTH-1:0]     ex_result,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_reg_write,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic [2:0]                ex_funct3,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    output logic [3:0]                dmem_wstrb,
    input  logic                      dmem_ack,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_result,
    output logic                      mem_stall,
    output logic                      mem_misaligned
);

    state_e                    state_q;
    logic                      dmem_req_q;
    logic                      dmem_we_q;
    logic [ADDR_WIDTH-1:0]     dmem_addr_q;
    logic [DATA_WIDTH-1:0]     dmem_wdata_q;
    logic [3:0]                dmem_wstrb_q;
    logic                      wb_valid_q;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
    logic [DATA_WIDTH-1:0]     wb_result_q;
    logic                      mem_misaligned_q;

    // Context of the in-flight memory op, needed when the ack returns
    logic [2:0]                hold_funct3_q;
    logic [1:0]                hold_addr_lo_q;
    logic [REG_ADDR_WIDTH-1:0] hold_rd_q;
    logic                      hold_wb_en_q;
    logic                      hold_load_q;

    logic                      is_memop;
    logic                      op_ok;
    logic                      issue;
    logic                      wb_en_ex;
    logic [2:0]                lane_funct3;
    logic [1:0]                lane_addr_lo;
    logic [DATA_WIDTH-1:0]     lane_wdata;
    logic [3:0]                lane_wstrb;
    logic [DATA_WIDTH-1:0]     lane_load;

    assign is_memop = ex_mem_read | ex_mem_write;
    assign op_ok    = access_ok(ex_funct3, ex_result[1:0]);
    assign issue    = (state_q == IDLE) && ex_valid && is_memop && op_ok;
    assign wb_en_ex = ex_reg_write && (ex_rd != '0);

    // Stores are steered from the live op at issue; loads are extracted
    // from the held op context when the ack arrives.
    assign lane_funct3  = (state_q == IDLE) ? ex_funct3      : hold_funct3_q;
    assign lane_addr_lo = (state_q == IDLE) ? ex_result[1:0] : hold_addr_lo_q;

    mem_lane_align u_lane (
        .funct3_i      (lane_funct3),
        .addr_lo_i     (lane_addr_lo),
        .is_store_i    (ex_mem_write),
        .store_data_i  (ex_store_data),
        .load_rdata_i  (dmem_rdata),
        .store_wdata_o (lane_wdata),
        .store_wstrb_o (lane_wstrb),
        .load_result_o (lane_load)
    );

    // Stall is gated by reset so the pipeline front is released the moment
    // reset asserts, even though upstream still holds the op.
    assign mem_stall = reset && (issue || (state_q == BUSY));

    // Stage FSM with registered memory request and write-back outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            dmem_req_q       <= 1'b0;
            dmem_we_q        <= 1'b0;
            dmem_addr_q      <= '0;
            dmem_wdata_q     <= '0;
            dmem_wstrb_q     <= '0;
            wb_valid_q       <= 1'b0;
            wb_rd_q          <= '0;
            wb_result_q      <= '0;
            mem_misaligned_q <= 1'b0;
            hold_funct3_q    <= '0;
            hold_addr_lo_q   <= '0;
            hold_rd_q        <= '0;
            hold_wb_en_q     <= 1'b0;
            hold_load_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register here samples pre-edge values regardless of order.
            mem_misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!ex_valid) begin
                        wb_valid_q <= 1'b0;
                    end else if (!is_memop) begin
                        wb_valid_q  <= wb_en_ex;
                        wb_rd_q     <= ex_rd;
                        wb_result_q <= ex_result;
                    end else if (!op_ok) begin
                        mem_misaligned_q <= 1'b1;
                        wb_valid_q       <= 1'b0;
                    end else begin
                        dmem_req_q     <= 1'b1;
                        dmem_we_q      <= ex_mem_write;
                        dmem_addr_q    <= {ex_result[ADDR_WIDTH-1:2], 2'b00};
                        dmem_wdata_q   <= lane_wdata;
                        dmem_wstrb_q   <= lane_wstrb;
                        hold_funct3_q  <= ex_funct3;
                        hold_addr_lo_q <= ex_result[1:0];
                        hold_rd_q      <= ex_rd;
                        hold_wb_en_q   <= wb_en_ex;
                        hold_load_q    <= ex_mem_read;
                        wb_valid_q     <= 1'b0;
                        state_q        <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        if (hold_load_q) begin
                            wb_valid_q  <= hold_wb_en_q;
                            wb_rd_q     <= hold_rd_q;
                            wb_result_q <= lane_load;
                        end else begin
                            wb_valid_q <= 1'b0;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // The held op retires here; upstream advances past it now.
                    wb_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dmem_req       = dmem_req_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_wstrb     = dmem_wstrb_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_result      = wb_result_q;
    assign mem_misaligned = mem_misaligned_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage between execute and write-back. Takes one micro-op per cycle from execute, runs loads/stores against data memory over a req/ack handshake, and produces the register-write result, destination register and valid strobe for write-back. Stalls the front of the pipeline (`mem_stall`) while a data-memory transaction is outstanding.

## Interface
- `DATA_WIDTH`, 32: data path width; only 32 is supported.
- `ADDR_WIDTH`, 32: byte address width.
- `REG_ADDR_WIDTH`, 5: register index width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: execute micro-op valid.
- `ex_result` in DATA_WIDTH: ALU result; the effective byte address for memory ops.
- `ex_store_data` in DATA_WIDTH: rs2 value for stores.
- `ex_rd` in REG_ADDR_WIDTH: destination register.
- `ex_reg_write` in 1: op writes a register.
- `ex_mem_read` / `ex_mem_write` in 1 each: load / store. Both high together is illegal and is not checked.
- `ex_funct3` in 3: access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out ADDR_WIDTH, `dmem_wdata` out DATA_WIDTH, `dmem_wstrb` out 4: data-memory request.
- `dmem_ack` in 1, `dmem_rdata` in DATA_WIDTH: data-memory response; rdata is valid in the ack cycle.
- `wb_valid` out 1, `wb_rd` out REG_ADDR_WIDTH, `wb_result` out DATA_WIDTH: to write-back.
- `mem_stall` out 1: combinational. Upstream holds every `ex_*` input stable while it is high.
- `mem_misaligned` out 1: one-cycle error pulse.

## Operation
- The FSM has three states: IDLE, BUSY, RESP. Reset values:
  - state = IDLE.
  - Every output register = 0.
  - `dmem_*` = 0.
- IDLE, `ex_valid` = 0: `wb_valid` <= 0.
- IDLE, non-memory op: `wb_valid` <= `ex_reg_write` && `ex_rd` != 0; `wb_rd` <= `ex_rd`; `wb_result` <= `ex_result`. Stays in IDLE.
- IDLE, memory op, aligned, legal `funct3`: register the request.
  - `dmem_addr` = {addr[31:2], 2'b00}.
  - `dmem_we` = `ex_mem_write`.
  - Store lanes: SB replicates the byte 4x, wstrb = 0001 << addr[1:0]. SH replicates the half 2x, wstrb = 0011 << addr[1:0]. SW sends the word, wstrb = 1111. wstrb = 0 for loads.
  - `dmem_req` <= 1; go to BUSY.
- Misaligned access (H with addr[0] = 1, W with addr[1:0] != 0) or illegal `funct3` on a memory op:
  - No request is issued.
  - `mem_misaligned` <= 1 for one cycle; `wb_valid` <= 0.
  - Consumed in one cycle; stays in IDLE.
- BUSY: `dmem_req` and all `dmem_*` are held stable until `dmem_ack`.
- On `dmem_ack`:
  - `dmem_req` <= 0.
  - Load: `wb_result` <= the byte/half picked by addr[1:0], sign-extended (B/H) or zero-extended (BU/HU). `wb_valid` <= `reg_write` && rd != 0.
  - Store: `wb_valid` <= 0.
  - Go to RESP.
- RESP: the held op retires; go to IDLE. The op is never re-issued.
- `mem_stall` = (IDLE && `ex_valid` && memop && aligned && legal) || BUSY.
- Reset asserted mid-transaction: immediately return to IDLE with all outputs 0. The outstanding transaction is abandoned, and data memory must drop it.

## Timing
- Non-memory op accepted at edge N: `wb_*` valid in cycle N+1. Throughput is 1 per cycle.
- Memory op issue cycle T: `dmem_req` is high from T+1. Ack in cycle T+1+k (k >= 0) gives `wb_valid` in cycle T+2+k (RESP). `mem_stall` is high from T through T+1+k.
- Ack in the first BUSY cycle gives minimum load latency 2 cycles, 3 cycles of occupancy.
- `dmem_ack` outside BUSY is ignored.
- `wb_valid`, `wb_rd`, `wb_result` and `mem_misaligned` are all registered.

## Structure
- Shared package holds:
  - `funct3` encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU).
  - FSM state encodings.
  - Widths from the system parameter header.
- Sub-module `mem_lane_align` (combinational) does store replication plus wstrb generation, and load byte/half extraction plus extension.
- The top level holds the FSM and output registers.

## Test plan
- ALU op, rd = 5, result 0x1234: `wb_valid` = 1, `wb_rd` = 5, `wb_result` = 0x1234 the next cycle; `mem_stall` never asserted.
- LB addr 0x103, memory word 0x80FF_00AA, ack after 2 BUSY cycles: `dmem_addr` = 0x100; `wb_result` = 0xFFFF_FF80 in RESP; `mem_stall` high for 3 cycles.
- SH addr 0x202, data 0xABCD: `dmem_wdata` = 0xABCD_ABCD, `wstrb` = 1100, `dmem_we` = 1; `wb_valid` stays 0.
- LW addr 0x301: no `dmem_req`, `mem_misaligned` pulses once, `wb_valid` = 0, `mem_stall` = 0.
- LHU addr 0x402 with ack held high in the RESP and IDLE cycles after the transaction: single retire, `wb_result` = upper half zero-extended; no duplicate request.
- Reset pulled low in BUSY: `dmem_req`, `wb_valid` and `mem_stall` go to 0 without waiting for a clock edge; the next op issues normally after release.
